// File: rtl/id_ex_skid_pkg.sv
// Shared constants and FSM state encoding for the ID/EX skid-buffered stage.
package id_ex_skid_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/id_ex_skid_ctrl.sv
// Occupancy FSM for the ID/EX skid buffer: registered handshake outputs and
// combinational load selects for the main (M) and skid (S) payload registers.
module id_ex_skid_ctrl
    import id_ex_skid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       in_valid_i,
    input  logic       out_ready_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic [1:0] occ_o,
    output logic       m_load_in,
    output logic       m_load_s,
    output logic       m_load_bubble,
    output logic       s_load_in,
    output logic       s_clear
);

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [1:0]  occ_q;
    logic        accept;
    logic        drain;

    assign accept = in_valid_i & in_ready_q;
    assign drain  = out_valid_q & out_ready_i;

    always_comb begin
        state_d       = state_q;
        m_load_in     = 1'b0;
        m_load_s      = 1'b0;
        m_load_bubble = 1'b0;
        s_load_in     = 1'b0;
        s_clear       = 1'b0;
        if (flush_i) begin
            // Redirect wins over everything, including a same-cycle accept.
            state_d       = SKID_EMPTY;
            m_load_bubble = 1'b1;
            s_clear       = 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        m_load_in = 1'b1;
                        state_d   = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        m_load_in = 1'b1;
                    end else if (accept) begin
                        s_load_in = 1'b1;
                        state_d   = SKID_FULL;
                    end else if (drain) begin
                        m_load_bubble = 1'b1;
                        state_d       = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (drain) begin
                        m_load_s = 1'b1;
                        s_clear  = 1'b1;
                        state_d  = SKID_ONE;
                    end
                end
                default: begin
                    state_d       = SKID_EMPTY;
                    m_load_bubble = 1'b1;
                    s_clear       = 1'b1;
                end
            endcase
        end
    end

    // Handshake outputs are derived from the next state so they leave a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID_FULL);
            out_valid_q <= (state_d != SKID_EMPTY);
            occ_q       <= state_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign occ_o       = occ_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid
// buffer; outputs come straight from the main register and show a NOP bubble when idle.
module id_ex_skid #(
    parameter int          XLEN     = 32,
    parameter int          RADDR_W  = 5,
    parameter logic [31:0] NOP_INST = id_ex_skid_pkg::INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               reg_wen_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_wen_o,
    output logic [1:0]         occ_o
);
    import id_ex_skid_pkg::*;

    logic m_load_in, m_load_s, m_load_bubble, s_load_in, s_clear;

    logic [31:0]        m_inst_q, m_inst_d, s_inst_q, s_inst_d;
    logic [XLEN-1:0]    m_addr_q, m_addr_d, s_addr_q, s_addr_d;
    logic [XLEN-1:0]    m_op1_q, m_op1_d, s_op1_q, s_op1_d;
    logic [XLEN-1:0]    m_op2_q, m_op2_d, s_op2_q, s_op2_d;
    logic [RADDR_W-1:0] m_rd_q, m_rd_d, s_rd_q, s_rd_d;
    logic               m_wen_q, m_wen_d, s_wen_q, s_wen_d;

    id_ex_skid_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .out_ready_i  (out_ready_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .occ_o        (occ_o),
        .m_load_in    (m_load_in),
        .m_load_s     (m_load_s),
        .m_load_bubble(m_load_bubble),
        .s_load_in    (s_load_in),
        .s_clear      (s_clear)
    );

    // Load selects are mutually exclusive; with none asserted the registers hold.
    always_comb begin
        m_inst_d = m_inst_q;  m_addr_d = m_addr_q;  m_op1_d = m_op1_q;
        m_op2_d  = m_op2_q;   m_rd_d   = m_rd_q;    m_wen_d = m_wen_q;
        if (m_load_in) begin
            m_inst_d = inst_i;  m_addr_d = inst_addr_i;  m_op1_d = op1_i;
            m_op2_d  = op2_i;   m_rd_d   = rd_addr_i;    m_wen_d = reg_wen_i;
        end else if (m_load_s) begin
            m_inst_d = s_inst_q;  m_addr_d = s_addr_q;  m_op1_d = s_op1_q;
            m_op2_d  = s_op2_q;   m_rd_d   = s_rd_q;    m_wen_d = s_wen_q;
        end else if (m_load_bubble) begin
            m_inst_d = NOP_INST;  m_addr_d = '0;  m_op1_d = '0;
            m_op2_d  = '0;        m_rd_d   = '0;  m_wen_d = 1'b0;
        end
    end

    always_comb begin
        s_inst_d = s_inst_q;  s_addr_d = s_addr_q;  s_op1_d = s_op1_q;
        s_op2_d  = s_op2_q;   s_rd_d   = s_rd_q;    s_wen_d = s_wen_q;
        if (s_load_in) begin
            s_inst_d = inst_i;  s_addr_d = inst_addr_i;  s_op1_d = op1_i;
            s_op2_d  = op2_i;   s_rd_d   = rd_addr_i;    s_wen_d = reg_wen_i;
        end else if (s_clear) begin
            s_inst_d = NOP_INST;  s_addr_d = '0;  s_op1_d = '0;
            s_op2_d  = '0;        s_rd_d   = '0;  s_wen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inst_q <= NOP_INST;  m_addr_q <= '0;  m_op1_q <= '0;
            m_op2_q  <= '0;        m_rd_q   <= '0;  m_wen_q <= 1'b0;
            s_inst_q <= NOP_INST;  s_addr_q <= '0;  s_op1_q <= '0;
            s_op2_q  <= '0;        s_rd_q   <= '0;  s_wen_q <= 1'b0;
        end else begin
            m_inst_q <= m_inst_d;  m_addr_q <= m_addr_d;  m_op1_q <= m_op1_d;
            m_op2_q  <= m_op2_d;   m_rd_q   <= m_rd_d;    m_wen_q <= m_wen_d;
            s_inst_q <= s_inst_d;  s_addr_q <= s_addr_d;  s_op1_q <= s_op1_d;
            s_op2_q  <= s_op2_d;   s_rd_q   <= s_rd_d;    s_wen_q <= s_wen_d;
        end
    end

    assign inst_o      = m_inst_q;
    assign inst_addr_o = m_addr_q;
    assign op1_o       = m_op1_q;
    assign op2_o       = m_op2_q;
    assign rd_addr_o   = m_rd_q;
    assign reg_wen_o   = m_wen_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid: accepted bundles are queued and compared
// in order as EX drains them; occupancy is checked against the queue depth.
module tb_id_ex_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        reg_wen_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;
    logic [1:0]  occ_o;

    int checks = 0;
    int errors = 0;
    bundle_t sb_q[$];

    id_ex_skid dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .occ_o(occ_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bundle_t mk(input logic [31:0] inst);
        bundle_t b;
        b.inst = inst;
        b.addr = $urandom;
        b.op1  = $urandom;
        b.op2  = $urandom;
        b.rd   = inst[11:7];
        b.wen  = 1'b1;
        return b;
    endfunction

    task automatic drive(input logic v, input bundle_t b);
        in_valid_i  = v;
        inst_i      = b.inst;
        inst_addr_i = b.addr;
        op1_i       = b.op1;
        op2_i       = b.op2;
        rd_addr_i   = b.rd;
        reg_wen_i   = b.wen;
    endtask

    // Monitor: compares the current state, then models the upcoming edge.
    always @(negedge clk) begin
        bundle_t exp_b;
        if (!rst) begin
            sb_q.delete();
            check_eq("rst_valid", out_valid_o, 0);
            check_eq("rst_inst", inst_o, NOP);
            check_eq("rst_wen", reg_wen_o, 0);
            check_eq("rst_rd", rd_addr_o, 0);
            check_eq("rst_ready", in_ready_o, 1);
            check_eq("rst_occ", occ_o, 0);
        end else begin
            check_eq("occ", occ_o, sb_q.size());
            check_eq("in_ready", in_ready_o, sb_q.size() < 2);
            check_eq("out_valid", out_valid_o, sb_q.size() != 0);
            if (!out_valid_o) begin
                check_eq("idle_inst", inst_o, NOP);
                check_eq("idle_addr", inst_addr_o, 0);
                check_eq("idle_ops", {op1_o, op2_o}, 0);
                check_eq("idle_rd_wen", {rd_addr_o, reg_wen_o}, 0);
            end
            if (out_valid_o && out_ready_i) begin
                check_eq("drain_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    exp_b = sb_q.pop_front();
                    check_eq("out_inst", inst_o, exp_b.inst);
                    check_eq("out_addr", inst_addr_o, exp_b.addr);
                    check_eq("out_ops", {op1_o, op2_o}, {exp_b.op1, exp_b.op2});
                    check_eq("out_rd_wen", {rd_addr_o, reg_wen_o}, {exp_b.rd, exp_b.wen});
                end
            end
            if (flush_i) sb_q.delete();
            else if (in_valid_i && in_ready_o)
                sb_q.push_back('{inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i});
        end
    end

    initial begin
        bundle_t a, b, c, d;
        // Reset held with junk inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk($urandom));
            out_ready_i = $urandom_range(0, 1);
            flush_i     = $urandom_range(0, 1);
            tick();
        end
        drive(1'b0, mk(NOP));
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("post_rst_occ", occ_o, 0);
        check_eq("post_rst_ready", in_ready_o, 1);

        // Streaming at full rate
        out_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, mk(32'h00A0_0093 + k));
            tick();
            check_eq("stream_inst", inst_o, 32'h00A0_0093 + k);
            check_eq("stream_occ", occ_o, 1);
        end
        drive(1'b0, mk(NOP));
        tick();
        check_eq("stream_empty", out_valid_o, 0);

        // Back-pressure: A held, B in skid, C refused until space frees
        out_ready_i = 1'b0;
        a = mk(32'h0010_0113); b = mk(32'h0020_0193); c = mk(32'h0030_0213);
        drive(1'b1, a); tick();
        check_eq("bp_a_out", inst_o, a.inst);
        drive(1'b1, b); tick();
        check_eq("bp_ready_low", in_ready_o, 0);
        check_eq("bp_full", occ_o, 2);
        drive(1'b1, c); tick();
        check_eq("bp_a_held", inst_o, a.inst);
        check_eq("bp_still_full", occ_o, 2);
        out_ready_i = 1'b1;
        tick();
        check_eq("bp_b_out", inst_o, b.inst);
        tick();
        check_eq("bp_c_out", inst_o, c.inst);
        drive(1'b0, mk(NOP));
        tick();
        check_eq("bp_drained", out_valid_o, 0);

        // Flush while FULL with an incoming bundle D
        out_ready_i = 1'b0;
        drive(1'b1, mk(32'h0040_0293)); tick();
        drive(1'b1, mk(32'h0050_0313)); tick();
        check_eq("fl_full", occ_o, 2);
        d = mk(32'h0DDD_0393);
        drive(1'b1, d);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, mk(NOP));
        check_eq("fl_valid", out_valid_o, 0);
        check_eq("fl_inst", inst_o, NOP);
        check_eq("fl_occ", occ_o, 0);
        check_eq("fl_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        tick();
        check_eq("fl_no_d", out_valid_o, 0);

        // Flush coinciding with a drain and an incoming bundle
        out_ready_i = 1'b0;
        drive(1'b1, mk(32'h0060_0413)); tick();
        drive(1'b1, mk(32'h0070_0493));
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, mk(NOP));
        check_eq("fd_valid", out_valid_o, 0);
        check_eq("fd_wen", reg_wen_o, 0);
        check_eq("fd_occ", occ_o, 0);

        // Async reset while FULL, asserted between edges
        out_ready_i = 1'b0;
        drive(1'b1, mk(32'h0080_0513)); tick();
        drive(1'b1, mk(32'h0090_0593)); tick();
        drive(1'b0, mk(NOP));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_valid", out_valid_o, 0);
        check_eq("ar_inst", inst_o, NOP);
        check_eq("ar_occ", occ_o, 0);
        check_eq("ar_ready", in_ready_o, 1);
        sb_q.delete();
        tick();
        rst = 1'b1;
        tick();
        out_ready_i = 1'b1;
        a = mk(32'h00B0_0613);
        drive(1'b1, a);
        tick();
        check_eq("ar_lat_valid", out_valid_o, 1);
        check_eq("ar_lat_inst", inst_o, a.inst);
        drive(1'b0, mk(NOP));
        tick();

        // Random traffic, checked by the monitor
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, mk($urandom));
            out_ready_i = $urandom_range(0, 2) != 0;
            flush_i     = $urandom_range(0, 15) == 0;
            tick();
        end
        flush_i = 1'b0;
        drive(1'b0, mk(NOP));
        out_ready_i = 1'b1;
        repeat (4) tick();
        check_eq("final_empty", sb_q.size(), 0);
        check_eq("final_valid", out_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
